// File: rtl/board_ctrl.sv
// Paddle-game sequencer: IDLE/PLAY/OVER flow, per-frame board movement
// and a saturating BCD mm:ss play timer.
module board_ctrl #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCREEN_W = 640,
    parameter int BOARD_W  = 64,
    parameter int BOARD_Y  = 296,
    parameter int STEP     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       frame_tick,
    input  logic       miss,
    output logic [9:0] board_x,
    output logic [9:0] board_y,
    output logic [1:0] state,
    output logic [3:0] sec0cnt,
    output logic [3:0] sec1cnt,
    output logic [3:0] min0cnt,
    output logic [3:0] min1cnt
);

    localparam logic [9:0] XMAX  = 10'(SCREEN_W - BOARD_W);
    localparam logic [9:0] XC    = 10'((SCREEN_W - BOARD_W) / 2);
    localparam logic [9:0] STEPV = 10'(STEP);
    localparam int         PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    s0_q, s0_d, s1_q, s1_d;
    logic [3:0]    m0_q, m0_d, m1_q, m1_d;
    logic          sec_tick, at_max;

    assign sec_tick = (presc_q == PMAX);
    assign at_max   = (m1_q == 4'd9) && (m0_q == 4'd9) &&
                      (s1_q == 4'd5) && (s0_q == 4'd9);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        presc_d = presc_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        m0_d    = m0_q;
        m1_d    = m1_q;
        unique case (state_q)
            IDLE: begin
                x_d     = XC;
                presc_d = '0;
                s0_d    = '0;
                s1_d    = '0;
                m0_d    = '0;
                m1_d    = '0;
                if (left | right) state_d = PLAY;
            end
            PLAY: begin
                if (frame_tick && left && !right)
                    x_d = (x_q < STEPV) ? 10'd0 : x_q - STEPV;
                else if (frame_tick && right && !left)
                    x_d = (x_q > XMAX - STEPV) ? XMAX : x_q + STEPV;
                presc_d = sec_tick ? '0 : presc_q + 1'b1;
                // BCD ripple carry; 99:59 is a hard ceiling
                if (sec_tick && !at_max) begin
                    s0_d = s0_q + 4'd1;
                    if (s0_q == 4'd9) begin
                        s0_d = '0;
                        s1_d = s1_q + 4'd1;
                        if (s1_q == 4'd5) begin
                            s1_d = '0;
                            m0_d = m0_q + 4'd1;
                            if (m0_q == 4'd9) begin
                                m0_d = '0;
                                m1_d = m1_q + 4'd1;
                            end
                        end
                    end
                end
                if (miss) state_d = OVER;
            end
            OVER: begin
                if (frame_tick && left && right) begin
                    state_d = IDLE;
                    x_d     = XC;
                    presc_d = '0;
                    s0_d    = '0;
                    s1_d    = '0;
                    m0_d    = '0;
                    m1_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= XC;
            presc_q <= '0;
            s0_q    <= '0;
            s1_q    <= '0;
            m0_q    <= '0;
            m1_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            presc_q <= presc_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            m0_q    <= m0_d;
            m1_q    <= m1_d;
        end
    end

    assign board_x = x_q;
    assign board_y = 10'(BOARD_Y);
    assign state   = state_q;
    assign sec0cnt = s0_q;
    assign sec1cnt = s1_q;
    assign min0cnt = m0_q;
    assign min1cnt = m1_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl against an arithmetic game model.
// Timer model: elapsed play clocks / CLK_HZ, capped at 5999 seconds.
module tb_board_ctrl;

    localparam int CLK_HZ = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left = 1'b0, right = 1'b0, frame_tick = 1'b0, miss = 1'b0;
    logic [9:0] board_x, board_y;
    logic [1:0] state;
    logic [3:0] sec0cnt, sec1cnt, min0cnt, min1cnt;

    int n_cmp = 0;
    int n_err = 0;

    // model: 0 idle, 1 play, 2 over
    int m_state;
    int m_x;
    int m_clks;

    board_ctrl #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .rst(rst), .left(left), .right(right),
        .frame_tick(frame_tick), .miss(miss),
        .board_x(board_x), .board_y(board_y), .state(state),
        .sec0cnt(sec0cnt), .sec1cnt(sec1cnt),
        .min0cnt(min0cnt), .min1cnt(min1cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_of(input int secs);
        int s, mm, ss;
        s  = (secs > 5999) ? 5999 : secs;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] exp_t();
        return bcd_of(m_clks / CLK_HZ);
    endfunction

    function automatic logic [15:0] dut_t();
        return {min1cnt, min0cnt, sec1cnt, sec0cnt};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_x     = 288;
        m_clks  = 0;
    endtask

    task automatic model_step(input logic l, r, ft, ms);
        case (m_state)
            0: begin
                m_x = 288;
                m_clks = 0;
                if (l || r) m_state = 1;
            end
            1: begin
                m_clks++;
                if (ft && l && !r) m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
                if (ft && r && !l) m_x = (m_x + 4 > 576) ? 576 : m_x + 4;
                if (ms) m_state = 2;
            end
            default: begin
                if (ft && l && r) begin
                    m_state = 0;
                    m_x = 288;
                    m_clks = 0;
                end
            end
        endcase
    endtask

    task automatic cyc(input logic l, r, ft, ms);
        @(negedge clk);
        left = l;
        right = r;
        frame_tick = ft;
        miss = ms;
        @(posedge clk);
        model_step(l, r, ft, ms);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        {left, right, frame_tick, miss} = 4'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic start_play();
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (board_x !== 10'd288 || board_y !== 10'd296 || state !== 2'b00) begin
            n_err++;
            $display("FAIL reset_pos got x=%0d y=%0d st=%0d exp 288 296 0",
                     board_x, board_y, state);
        end
        n_cmp++;
        if (dut_t() !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_timer got %h exp 0000", dut_t());
        end
    endtask

    task automatic test_start_move();
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (state !== 2'b01) begin
            n_err++;
            $display("FAIL idle_to_play got %0d exp 1", state);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
        end
        n_cmp++;
        if (board_x !== 10'd300) begin
            n_err++;
            $display("FAIL right_3_ticks got %0d exp 300", board_x);
        end
    endtask

    task automatic test_saturate();
        start_play();
        for (int i = 0; i < 80; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (board_x !== 10'd0) begin
            n_err++;
            $display("FAIL left_sat got %0d exp 0", board_x);
        end
        for (int i = 0; i < 160; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (board_x !== 10'd576) begin
            n_err++;
            $display("FAIL right_sat got %0d exp 576", board_x);
        end
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (board_x !== 10'd576 || state !== 2'b01) begin
            n_err++;
            $display("FAIL both_hold got x=%0d st=%0d exp 576 1", board_x, state);
        end
    endtask

    task automatic test_timer();
        start_play();
        for (int i = 0; i < 600; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_t() !== 16'h0100 || dut_t() !== exp_t()) begin
            n_err++;
            $display("FAIL timer_01_00 got %h exp 0100", dut_t());
        end
        while (m_clks < 5990) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_t() !== 16'h0959) begin
            n_err++;
            $display("FAIL timer_09_59 got %h exp 0959", dut_t());
        end
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_t() !== 16'h1000) begin
            n_err++;
            $display("FAIL timer_10_00 got %h exp 1000", dut_t());
        end
        while (m_clks < 59990) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_t() !== 16'h9959) begin
            n_err++;
            $display("FAIL timer_99_59 got %h exp 9959", dut_t());
        end
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_t() !== 16'h9959) begin
            n_err++;
            $display("FAIL timer_sat got %h exp 9959", dut_t());
        end
    endtask

    task automatic test_over();
        start_play();
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        while (m_clks < 70) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (state !== 2'b10 || dut_t() !== 16'h0007) begin
            n_err++;
            $display("FAIL miss_over got st=%0d t=%h exp 2 0007", state, dut_t());
        end
        for (int i = 0; i < 50; i++) begin
            logic l, r;
            l = 1'($urandom);
            r = l ? 1'b0 : 1'($urandom);
            cyc(l, r, 1'b1, 1'($urandom));
        end
        n_cmp++;
        if (board_x !== 10'd284 || dut_t() !== 16'h0007 || state !== 2'b10) begin
            n_err++;
            $display("FAIL over_frozen got x=%0d t=%h st=%0d exp 284 0007 2",
                     board_x, dut_t(), state);
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (state !== 2'b00 || board_x !== 10'd288 || dut_t() !== 16'h0000) begin
            n_err++;
            $display("FAIL over_to_idle got st=%0d x=%0d t=%h exp 0 288 0000",
                     state, board_x, dut_t());
        end
    endtask

    task automatic test_async_reset();
        start_play();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (state !== 2'b00 || board_x !== 10'd288 || dut_t() !== 16'h0000) begin
            n_err++;
            $display("FAIL async_rst got st=%0d x=%0d t=%h exp 0 288 0000",
                     state, board_x, dut_t());
        end
        #1 rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (state !== 2'b00 || board_x !== 10'd288) begin
            n_err++;
            $display("FAIL idle_miss got st=%0d x=%0d exp 0 288", state, board_x);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic l, r, ft, ms;
            l  = 1'($urandom);
            r  = 1'($urandom);
            ft = ($urandom_range(0, 2) == 0);
            ms = ($urandom_range(0, 79) == 0);
            cyc(l, r, ft, ms);
            n_cmp++;
            if (state !== 2'(m_state) || board_x !== 10'(m_x) ||
                dut_t() !== exp_t()) begin
                n_err++;
                $display("FAIL rand_%0d got st=%0d x=%0d t=%h exp %0d %0d %h",
                         i, state, board_x, dut_t(), m_state, m_x, exp_t());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start_move();
        test_saturate();
        test_timer();
        test_over();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
